// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one AHB-to-APB bridge between NREQ requesters.
// Accepts one command at a time, decodes the APB slave, and returns done/err/rdata to the winner.
module apb_req_arbiter #(
  parameter int NREQ    = 3,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 h_clk,
  input  logic                 h_reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 valid,
  output logic                 h_write,
  output logic [31:0]          h_addr,
  output logic [31:0]          h_wdata,
  output logic [2:0]           tempsel,
  input  logic                 h_readyout,
  input  logic [31:0]          p_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] MIN_C = 8'(MIN_LAT);
  localparam logic [7:0] TO_C  = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              hwrite_q, hwrite_d;
  logic [31:0]       haddr_q, haddr_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic [2:0]        tsel_q, tsel_d;

  logic [IW-1:0]     pick;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_tsel;

  // Scan from the farthest offset down so the nearest requester after ptr_q wins.
  always_comb begin
    pick = ptr_q;
    for (int j = NREQ; j >= 1; j--) begin
      if (req[(int'(ptr_q) + j) % NREQ]) pick = IW'((int'(ptr_q) + j) % NREQ);
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (sel_addr[9:8])
      2'b00:   sel_tsel = 3'b001;
      2'b01:   sel_tsel = 3'b010;
      2'b10:   sel_tsel = 3'b100;
      default: sel_tsel = 3'b000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    hwrite_d = hwrite_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    tsel_d   = tsel_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d = pick;
          gnt_d = NREQ'(1) << pick;
          if (sel_tsel != 3'b000) begin
            hwrite_d = sel_write;
            haddr_d  = sel_addr;
            hwdata_d = sel_wdata;
            tsel_d   = sel_tsel;
            valid_d  = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            // Unmapped slave: answer with an error without touching the bridge.
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Early ready is the bridge's stale flag from the previous transfer.
        if (cnt_q >= MIN_C && h_readyout) begin
          err_d   = 1'b0;
          rdata_d = hwrite_q ? rdata_q : p_rdata;
          state_d = S_RESP;
        end else if (cnt_q == TO_C) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        tsel_d  = '0;
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge h_clk or negedge h_reset) begin
    if (!h_reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      hwrite_q <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      tsel_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      hwrite_q <= hwrite_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      tsel_q   <= tsel_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign valid   = valid_q;
  assign h_write = hwrite_q;
  assign h_addr  = haddr_q;
  assign h_wdata = hwdata_q;
  assign tempsel = tsel_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: reset, fairness, a table of single transfers,
// and a randomized run against a transaction-level reference model.
module tb_apb_req_arbiter;
  localparam int NREQ    = 3;
  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 15;

  logic                h_clk = 1'b0;
  logic                h_reset;
  logic [NREQ-1:0]     req, req_write;
  logic [32*NREQ-1:0]  req_addr, req_wdata;
  logic [NREQ-1:0]     gnt, done;
  logic                err, valid, h_write, h_readyout;
  logic [31:0]         rdata, h_addr, h_wdata, p_rdata;
  logic [2:0]          tempsel;

  int n_chk  = 0;
  int n_fail = 0;

  apb_req_arbiter #(.NREQ(NREQ), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
    .h_clk(h_clk), .h_reset(h_reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .valid(valid), .h_write(h_write),
    .h_addr(h_addr), .h_wdata(h_wdata), .tempsel(tempsel),
    .h_readyout(h_readyout), .p_rdata(p_rdata)
  );

  always #5 h_clk = ~h_clk;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // WAIT cycles with ready low before it rises
    logic [31:0] prdata;
    logic [2:0]  exp_tsel;  // 0 means decode error, no bridge command
    int          exp_lat;   // grant sample to done sample, in cycles
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_write[idx]           = wr;
    req_addr[32*idx +: 32]   = addr;
    req_wdata[32*idx +: 32]  = wdata;
  endtask

  function automatic int gnt_index(input logic [NREQ-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int m, vcnt;
    bit got;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[v.idx] = 1'b1;
    set_cmd(v.idx, v.wr, v.addr, v.wdata);
    p_rdata    = v.prdata;
    h_readyout = 1'b1;
    req[v.idx] = 1'b1;
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge h_clk);
      if (gnt != '0) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL vec_grant_wait: got no grant, required grant to %0d", v.idx);
      req = '0;
      return;
    end
    chk("vec_gnt", 32'(gnt), 32'(oh));
    chk("vec_tempsel", 32'(tempsel), 32'(v.exp_tsel));
    chk("vec_valid", 32'(valid), 32'(v.exp_tsel != 3'b000));
    if (valid) begin
      chk("vec_h_write", 32'(h_write), 32'(v.wr));
      chk("vec_h_addr", h_addr, v.addr);
      chk("vec_h_wdata", h_wdata, v.wdata);
    end
    vcnt = int'(valid);
    m = 0;
    got = 0;
    while (!got && m < 40) begin
      h_readyout = (m + 1 < 2) ? 1'b1 : ((m + 1 - 2) >= v.delay);
      @(negedge h_clk);
      m++;
      if (valid) vcnt++;
      if (done != '0) got = 1;
    end
    chk("vec_latency", m, v.exp_lat);
    chk("vec_done", 32'(done), 32'(oh));
    chk("vec_err", 32'(err), 32'(v.exp_err));
    chk("vec_rdata", rdata, v.exp_rdata);
    chk("vec_gnt_clear", 32'(gnt), 0);
    chk("vec_valid_count", vcnt, (v.exp_tsel != 3'b000) ? 1 : 0);
    req[v.idx] = 1'b0;
    h_readyout = 1'b0;
  endtask

  task automatic fairness();
    int order[$];
    int dn, bad, gi;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] one;
    one = 1;
    dn = 0; bad = 0; prev = '0;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, 32'h10 * i, 32'h1000 + i);
    h_readyout = 1'b1;
    req = '1;
    for (int c = 0; c < 200 && dn < 6; c++) begin
      @(negedge h_clk);
      if ($countones(gnt) > 1) bad++;
      if (gnt != '0 && prev == '0) order.push_back(gnt_index(gnt));
      if (done != '0) begin
        gi = (dn < order.size()) ? order[dn] : 0;
        chk("fair_done", 32'(done), 32'(one << gi));
        dn++;
        if (dn == 6) req = '0;
      end
      prev = gnt;
    end
    chk("fair_done_count", dn, 6);
    chk("fair_onehot", bad, 0);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) chk("fair_order", order[i], i % NREQ);
      else begin
        n_chk++; n_fail++;
        $display("FAIL fair_order: missing grant %0d, required requester %0d", i, i % NREQ);
      end
    end
    req = '0;
    @(negedge h_clk);
  endtask

  task automatic random_phase(input int ncyc);
    bit mbusy, mdn, e_valid, found;
    int mwin, mm, mptr, w, k;
    logic mwr;
    logic [31:0] maddr, mwdata, mrdata, prd;
    logic perr;
    logic [NREQ-1:0] e_gnt, e_done, one;
    one = 1;
    mbusy = 0; mdn = 0; mwin = 0; mm = 0; mptr = NREQ - 1;
    mwr = 0; maddr = 0; mwdata = 0; mrdata = 0; prd = 0; perr = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge h_clk);
      e_done = '0;
      e_valid = 0;
      if (mdn) begin
        e_done = one << mwin;
        mrdata = prd;
        mbusy = 0; mdn = 0;
        mptr = mwin;
      end else if (mbusy) begin
        mm++;
        if (maddr[9:8] != 2'b11 && mm >= 2) begin
          w = mm - 2;
          if (w >= MIN_LAT && h_readyout) begin
            mdn = 1; perr = 0;
            prd = mwr ? mrdata : p_rdata;
          end else if (w == TIMEOUT) begin
            mdn = 1; perr = 1; prd = 0;
          end
        end
      end else if (req != '0) begin
        found = 0;
        k = 1;
        while (!found) begin
          if (req[(mptr + k) % NREQ]) begin
            found = 1;
            mwin = (mptr + k) % NREQ;
          end
          k++;
        end
        mbusy = 1; mm = 0;
        mwr    = req_write[mwin];
        maddr  = req_addr[32*mwin +: 32];
        mwdata = req_wdata[32*mwin +: 32];
        if (maddr[9:8] == 2'b11) begin
          mdn = 1; perr = 1; prd = 0;
        end else e_valid = 1;
      end
      e_gnt = mbusy ? (one << mwin) : '0;
      chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd_done", 32'(done), 32'(e_done));
      chk("rnd_valid", 32'(valid), 32'(e_valid));
      if (e_done != '0) begin
        chk("rnd_err", 32'(err), 32'(perr));
        chk("rnd_rdata", rdata, mrdata);
      end
      if (e_valid) begin
        chk("rnd_tempsel", 32'(tempsel), 32'(3'b001 << maddr[9:8]));
        chk("rnd_h_addr", h_addr, maddr);
        chk("rnd_h_write", 32'(h_write), 32'(mwr));
        chk("rnd_h_wdata", h_wdata, mwdata);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (e_done[i]) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_cmd(i, 1'($urandom), $urandom, $urandom);
            req[i] = 1'b1;
          end
        end else if (mbusy && mwin == i && $urandom_range(0, 1) == 1) begin
          set_cmd(i, 1'($urandom), $urandom, $urandom);
        end
      end
      case ((cyc / 300) % 3)
        0:       h_readyout = 1'($urandom);
        1:       h_readyout = ($urandom_range(0, 7) == 0);
        default: h_readyout = 1'b0;
      endcase
      p_rdata = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit got;
    vecs[0] = '{1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0,  32'h0,         3'b010, 5,  1'b0, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h0000_0008, 32'h0,         4,  32'h1234_5678, 3'b001, 7,  1'b0, 32'h1234_5678};
    vecs[2] = '{2, 1'b0, 32'h0000_0300, 32'h0,         0,  32'h5555_5555, 3'b000, 1,  1'b1, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h0000_0200, 32'h0,         99, 32'h7777_7777, 3'b100, 18, 1'b1, 32'h0};
    vecs[4] = '{2, 1'b0, 32'h0000_01FC, 32'h0,         1,  32'hA5A5_5A5A, 3'b010, 5,  1'b0, 32'hA5A5_5A5A};
    vecs[5] = '{1, 1'b1, 32'h0000_0000, 32'h0F0F_0F0F, 13, 32'h9999_9999, 3'b001, 16, 1'b0, 32'hA5A5_5A5A};
    vecs[6] = '{0, 1'b0, 32'h0000_02F0, 32'h0,         15, 32'hCAFE_F00D, 3'b100, 18, 1'b0, 32'hCAFE_F00D};
    vecs[7] = '{1, 1'b1, 32'h0000_03FC, 32'h1,         0,  32'h0,         3'b000, 1,  1'b1, 32'h0};

    h_reset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    h_readyout = 1'b0; p_rdata = '0;
    #1 h_reset = 1'b0;
    @(negedge h_clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_h_write", 32'(h_write), 0);
    chk("rst_h_addr", h_addr, 0);
    chk("rst_h_wdata", h_wdata, 0);
    chk("rst_tempsel", 32'(tempsel), 0);
    h_reset = 1'b1;

    // Reset in the middle of a WAIT phase drops the transfer silently.
    set_cmd(1, 1'b1, 32'h0000_0104, 32'h1111_2222);
    req[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge h_clk);
      if (gnt != '0) got = 1;
    end
    chk("midwait_grant_seen", 32'(got), 1);
    repeat (3) @(negedge h_clk);
    h_reset = 1'b0;
    #1;
    chk("midwait_gnt", 32'(gnt), 0);
    chk("midwait_valid", 32'(valid), 0);
    chk("midwait_tempsel", 32'(tempsel), 0);
    chk("midwait_h_addr", h_addr, 0);
    chk("midwait_h_wdata", h_wdata, 0);
    chk("midwait_done", 32'(done), 0);
    req = '0;
    @(negedge h_clk);
    h_reset = 1'b1;
    h_readyout = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge h_clk);
      if (done != '0) cnt++;
    end
    chk("midwait_no_done", cnt, 0);

    fairness();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    @(negedge h_clk);
    req = '0;
    h_reset = 1'b0;
    @(negedge h_clk);
    h_reset = 1'b1;
    random_phase(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
